vga_sync_rx: RTL and testbench

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx.sv | 142 ++++++++++++++
 tb/tb_vga_sync_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position from a VGA sync stream, checks its timing and reports lock
module vga_sync_rx #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_WHOLE_LINE  = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_WHOLE_FRAME = 525,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] column,
  output logic [9:0] row,
  output logic       visible,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT_PORCH;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT_PORCH;
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0] TIMEOUT = 11'(2 * H_WHOLE_LINE);
  // an inconsistent or oversized timing set can never be tracked, so it never reports lock
  localparam bit TIMING_OK =
    (H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH == H_WHOLE_LINE) &&
    (V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH == V_WHOLE_FRAME) &&
    (H_WHOLE_LINE <= 1023) && (V_WHOLE_FRAME <= 1023);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t state, state_nxt;
  logic h_q, h_q2, v_q, v_q2;
  logic h_fall, v_fall, col_wrap;
  logic [10:0] line_len, line_cnt;
  logic frame_bad, line_bad, frame_good, timeout;
  logic [GW-1:0] good_cnt, good_cnt_nxt, good_inc;
  logic sync_err_nxt;

  assign h_fall     = h_q2 && !h_q;
  assign v_fall     = v_q2 && !v_q;
  assign col_wrap   = !h_fall && column == 10'(H_WHOLE_LINE - 1);
  assign line_bad   = h_fall && line_len != 11'(H_WHOLE_LINE);
  assign timeout    = !h_fall && line_len >= TIMEOUT;
  // a coincident hsync fall still belongs to the frame that the vsync fall closes
  assign frame_good = !frame_bad && !line_bad &&
                      ({1'b0, line_cnt} + {11'd0, h_fall} == 12'(V_WHOLE_FRAME));
  assign good_inc   = good_cnt + GW'(1);

  assign locked      = TIMING_OK && state == LOCKED;
  assign visible     = locked && column < 10'(H_VISIBLE) && row < 10'(V_VISIBLE);
  assign frame_start = locked && column == 10'd0 && row == 10'd0;

  // sample the syncs and keep the previous sample; idle-high reset avoids a false fall on release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q  <= 1'b1;
      h_q2 <= 1'b1;
      v_q  <= 1'b1;
      v_q2 <= 1'b1;
    end else begin
      h_q  <= hsync_in;
      h_q2 <= h_q;
      v_q  <= vsync_in;
      v_q2 <= v_q;
    end
  end

  // free-running pixel position, re-anchored by each sync fall (vsync load beats a row step)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      column <= 10'd0;
      row    <= 10'd0;
    end else begin
      column <= h_fall ? 10'(H_SYNC_START + 1) : col_wrap ? 10'd0 : column + 10'd1;
      row    <= v_fall ? 10'(V_SYNC_START) : !col_wrap ? row :
                row == 10'(V_WHOLE_FRAME - 1) ? 10'd0 : row + 10'd1;
    end
  end

  // measure the line period and count lines per frame, remembering any bad line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_len  <= 11'd0;
      line_cnt  <= 11'd0;
      frame_bad <= 1'b0;
    end else begin
      line_len  <= h_fall ? 11'd1 : (&line_len) ? line_len : line_len + 11'd1;
      line_cnt  <= v_fall ? 11'd0 : !h_fall ? line_cnt : (&line_cnt) ? line_cnt : line_cnt + 11'd1;
      frame_bad <= v_fall ? 1'b0 : frame_bad || line_bad;
    end
  end

  // lock state, good-frame count and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  // acquire on a vsync fall, qualify LOCK_FRAMES good frames, drop on any violation
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    sync_err_nxt = 1'b0;
    case (state)
      SEARCH: begin
        if (v_fall) begin
          state_nxt    = CHECK;
          good_cnt_nxt = '0;
        end
      end
      CHECK: begin
        if (timeout) begin
          state_nxt = SEARCH;
        end else if (v_fall) begin
          good_cnt_nxt = frame_good ? good_inc : '0;
          state_nxt    = (frame_good && good_inc == GW'(LOCK_FRAMES)) ? LOCKED : CHECK;
        end
      end
      LOCKED: begin
        if (line_bad || timeout || (v_fall && !frame_good)) begin
          state_nxt    = SEARCH;
          sync_err_nxt = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: random VGA stream disturbances checked against an event-level lock model
module tb_vga_sync_rx;
  localparam int HV = 16, HFP = 4, HSP = 6, HBP = 6, HW = 32;
  localparam int VV = 10, VFP = 2, VSP = 2, VBP = 4, VW = 18;
  localparam int LF = 2;
  localparam int HSS = HV + HFP, VSS = VV + VFP;
  localparam int M_SEARCH = 0, M_CHECK = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset_n, hsync_in, vsync_in;
  logic [9:0] column, row;
  logic visible, locked, frame_start, sync_err;

  int total = 0, bad = 0;
  int n = 0, last_hf = 0, mst = M_SEARCH, good = 0, lines = 0;
  bit ph = 1, pv = 1, fbad = 0, p_locked = 0, p_err = 0;
  bit exp_locked = 0, exp_err = 0, trust = 0;

  vga_sync_rx #(
    .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP), .H_WHOLE_LINE(HW),
    .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .V_WHOLE_FRAME(VW),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .column(column), .row(row), .visible(visible), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mst = M_SEARCH; good = 0; lines = 0; fbad = 0;
    ph = 1; pv = 1; last_hf = n;
    p_locked = 0; p_err = 0; exp_locked = 0; exp_err = 0;
  endtask

  // spec rules applied to time stamps of sync falls; result shows up one edge later
  task automatic model(input logic h, input logic v);
    bit hf, vf, to, lbad, fgood;
    int iv;
    n++;
    hf = ph && !h;
    vf = pv && !v;
    ph = h;
    pv = v;
    iv = n - last_hf;
    if (iv > 2047) iv = 2047;
    to = !hf && iv >= 2 * HW;
    lbad = hf && iv != HW;
    fgood = !fbad && !lbad && (lines + int'(hf) == VW);
    p_err = 0;
    if (mst == M_SEARCH) begin
      if (vf) begin mst = M_CHECK; good = 0; end
    end else if (mst == M_CHECK) begin
      if (to) mst = M_SEARCH;
      else if (vf) begin
        good = fgood ? good + 1 : 0;
        if (good == LF) mst = M_LOCKED;
      end
    end else if (lbad || to || (vf && !fgood)) begin
      mst = M_SEARCH;
      p_err = 1;
    end
    if (vf) begin lines = 0; fbad = 0; end
    else if (hf) begin lines++; fbad = fbad || lbad; end
    if (hf) last_hf = n;
    p_locked = (mst == M_LOCKED);
  endtask

  // one pixel: drive syncs, let the DUT sample, compare on the falling edge
  task automatic step(input logic h, input logic v, input int c, input int r);
    bit was, full, mk2;
    logic [23:0] obs, expv;
    hsync_in = h;
    vsync_in = v;
    @(posedge clk);
    was = exp_locked;
    exp_locked = p_locked;
    exp_err = p_err;
    if (exp_locked && !was) trust = 1;
    model(h, v);
    @(negedge clk);
    full = exp_locked && trust;
    mk2 = !exp_locked || trust;
    obs = {locked, sync_err, visible && mk2, frame_start && mk2,
           full ? column : 10'd0, full ? row : 10'd0};
    expv = {exp_locked, exp_err, full && c < HV && r < VV, full && c == 0 && r == 0,
            full ? 10'(c) : 10'd0, full ? 10'(r) : 10'd0};
    chk("cycle", 32'(obs), 32'(expv));
  endtask

  task automatic gen_frame(input int nl, input int sr, input int sl, input int lim);
    int k = 0;
    for (int r = 0; r < nl; r++)
      for (int c = 0; c < ((r == sr) ? sl : HW); c++) begin
        if (lim >= 0 && k >= lim) return;
        step(!(c >= HSS && c < HSS + HSP), !(r >= VSS && r < VSS + VSP), c, r);
        k++;
      end
  endtask

  task automatic good_frames(input int cnt);
    for (int f = 0; f < cnt; f++) gen_frame(VW, -1, HW, -1);
  endtask

  initial begin
    int sc, d, len;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'({locked, sync_err, visible, frame_start, column, row}), 32'd0);
    reset_n = 1'b1;
    model_reset();
    good_frames(5);
    chk("locked_after_start", 32'(locked), 32'd1);
    for (int i = 0; i < 12; i++) begin
      sc = (i < 5) ? i : int'($urandom_range(0, 4));
      case (sc)
        1: begin
          trust = 0;
          d = int'($urandom_range(1, 4));
          gen_frame(VW, int'($urandom_range(0, VW - 1)), ($urandom_range(0, 1) != 0) ? HW + d : HW - d, -1);
        end
        2: begin
          trust = 0;
          gen_frame(($urandom_range(0, 1) != 0) ? VW + 1 : VW - 1, -1, HW, -1);
        end
        3: begin
          len = int'($urandom_range(40, 120));
          for (int k = 0; k < len; k++) step(1'b1, 1'b1, k % HW, (k / HW) % VW);
          trust = 0;
        end
        4: begin
          gen_frame(VW, -1, HW, int'($urandom_range(1, VW * HW - 1)));
          @(posedge clk);
          #2 reset_n = 1'b0;
          #1 chk("reset_async", 32'({locked, sync_err, visible, frame_start, column, row}), 32'd0);
          repeat (2) @(posedge clk);
          @(negedge clk);
          hsync_in = 1'b1;
          vsync_in = 1'b1;
          reset_n = 1'b1;
          model_reset();
          trust = 0;
          for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, 0, 0);
            chk("reset_count", 32'({row, column}), 32'(k));
          end
        end
        default: ;
      endcase
      good_frames(5);
      chk("relocked", 32'(locked), 32'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
